// File: rtl/z80_seq_pkg.sv
// z80_seq_pkg: definitions shared by the EX (SP),rr memory-phase sequencer
// and its bus transfer helper.
//   seq_state_t     : sequencer state encoding (also exported for debug)
//   REG_SEL_*       : register pair select codes (HL/IX/IY, 3 reserved)
//   pad_cnt_w()     : width of the internal pad T-state down-counter
package z80_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RPAD = 3'd2,
    S_WR   = 3'd3,
    S_WPAD = 3'd4,
    S_DONE = 3'd5
  } seq_state_t;

  localparam logic [1:0] REG_SEL_HL   = 2'd0;
  localparam logic [1:0] REG_SEL_IX   = 2'd1;
  localparam logic [1:0] REG_SEL_IY   = 2'd2;
  localparam logic [1:0] REG_SEL_RSVD = 2'd3;

  // clog2(max(rd_pad, wr_pad) + 1), never narrower than one bit so the
  // counter still exists when both pads are zero.
  function automatic int pad_cnt_w(input int rd_pad, input int wr_pad);
    int m;
    m = (rd_pad > wr_pad) ? rd_pad : wr_pad;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/z80_bus_xfer.sv
// z80_bus_xfer: single-transfer request holder between the sequencer and
// the memory bus controller.
//   go/wr/addr/wdata : transfer description from the sequencer; must stay
//                      constant while go is high
//   mem_req/mem_wr/mem_addr/mem_wdata : bus side of the same transfer
//   mem_ack          : one-cycle completion pulse from the bus
//   xfer_ack         : completion seen by the sequencer
//
// Handshake: mem_req is the request, mem_ack the completion. A transfer
// completes in the cycle mem_req and mem_ack are both high; an ack while
// mem_req is low is dropped. mem_req may stay high into the next cycle, in
// which case that cycle starts the next transfer.
module z80_bus_xfer #(
  parameter int ADDR_W = 16
) (
  input  logic              go,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              xfer_ack
);

  assign mem_req   = go;
  assign mem_wr    = wr;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign xfer_ack  = go & mem_ack;

endmodule

// File: rtl/z80_ex_sp_seq.sv
// z80_ex_sp_seq: memory phase of EX (SP),HL/IX/IY. Reads REG_BYTES bytes
// upward from SP, pads, writes the latched register bytes back in reverse
// order, pads again, then presents the read value on reg_out.
//   start/reg_sel/sp_in/reg_in : request from the decoder (sampled in IDLE)
//   mem_*                      : req/ack memory bus
//   busy/done                  : operation in flight / one-cycle completion
//   reg_out/reg_sel_out        : exchanged value and target pair
//   state_dbg                  : current sequencer state
// Optional: define Z80_EX_SP_TRACE_EN to add trace_valid, trace_raddr,
// trace_rdata, trace_waddr, trace_wdata and trace_tcycles (bus-order log).
module z80_ex_sp_seq
  import z80_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int REG_BYTES = 2,
  parameter int RD_PAD    = 1,
  parameter int WR_PAD    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               reg_sel,
  input  logic [ADDR_W-1:0]        sp_in,
  input  logic [8*REG_BYTES-1:0]   reg_in,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [8*REG_BYTES-1:0]   reg_out,
  output logic [1:0]               reg_sel_out,
  output seq_state_t               state_dbg
`ifdef Z80_EX_SP_TRACE_EN
  ,
  output logic                     trace_valid,
  output logic [REG_BYTES*ADDR_W-1:0] trace_raddr,
  output logic [8*REG_BYTES-1:0]   trace_rdata,
  output logic [REG_BYTES*ADDR_W-1:0] trace_waddr,
  output logic [8*REG_BYTES-1:0]   trace_wdata,
  output logic [7:0]               trace_tcycles
`endif
);

  localparam int N     = REG_BYTES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = pad_cnt_w(RD_PAD, WR_PAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_PAD);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_PAD);

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  sp_q;
  logic [8*N-1:0]     reg_q;
  logic [8*N-1:0]     shadow_q;
  logic [8*N-1:0]     reg_out_q;
  logic [1:0]         sel_q;

  logic               accept;
  logic               xfer_go;
  logic               xfer_wr;
  logic [ADDR_W-1:0]  xfer_addr;
  logic [7:0]         xfer_wdata;
  logic               xfer_ack;

  assign accept     = start && (reg_sel != REG_SEL_RSVD);
  assign xfer_go    = (state_q == S_RD) || (state_q == S_WR);
  assign xfer_wr    = (state_q == S_WR);
  // Address arithmetic wraps modulo 2^ADDR_W by truncation.
  assign xfer_addr  = sp_q + ADDR_W'(idx_q);
  assign xfer_wdata = reg_q[{idx_q, 3'b000} +: 8];

  z80_bus_xfer #(.ADDR_W(ADDR_W)) u_xfer (
    .go        (xfer_go),
    .wr        (xfer_wr),
    .addr      (xfer_addr),
    .wdata     (xfer_wdata),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .xfer_ack  (xfer_ack)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RD;
      S_RD:   if (xfer_ack && idx_q == IDX_LAST)
                state_d = (RD_PAD == 0) ? S_WR : S_RPAD;
      // Counter is loaded with the pad length, so the state lasts exactly
      // that many cycles.
      S_RPAD: if (cnt_q <= CNT_W'(1)) state_d = S_WR;
      S_WR:   if (xfer_ack && idx_q == '0)
                state_d = (WR_PAD == 0) ? S_DONE : S_WPAD;
      S_WPAD: if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      sp_q      <= '0;
      reg_q     <= '0;
      shadow_q  <= '0;
      reg_out_q <= '0;
      sel_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) begin
          sp_q  <= sp_in;
          reg_q <= reg_in;
          sel_q <= reg_sel;
          idx_q <= '0;
        end
        S_RD: if (xfer_ack) begin
          shadow_q[{idx_q, 3'b000} +: 8] <= mem_rdata;
          if (idx_q == IDX_LAST) cnt_q <= RD_CNT;
          else                   idx_q <= idx_q + 1'b1;
        end
        S_RPAD: begin
          cnt_q <= cnt_q - 1'b1;
          idx_q <= IDX_LAST;
        end
        S_WR: if (xfer_ack) begin
          if (idx_q == '0) cnt_q <= WR_CNT;
          else             idx_q <= idx_q - 1'b1;
        end
        S_WPAD: cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      // The register file only ever sees a complete exchange; an aborted
      // operation leaves reg_out untouched.
      if (state_d == S_DONE) reg_out_q <= shadow_q;
    end
  end

  assign busy        = (state_q == S_RD) || (state_q == S_RPAD) ||
                       (state_q == S_WR) || (state_q == S_WPAD);
  assign done        = (state_q == S_DONE);
  assign reg_out     = reg_out_q;
  assign reg_sel_out = sel_q;
  assign state_dbg   = state_q;

`ifdef Z80_EX_SP_TRACE_EN
  logic [N*ADDR_W-1:0] tr_raddr_q, tr_waddr_q;
  logic [8*N-1:0]      tr_rdata_q, tr_wdata_q;
  logic [7:0]          tr_tcyc_q;
  int                  rpos, wpos;

  // Writes go out highest index first, so bus slot = N-1-idx.
  assign rpos = int'(idx_q);
  assign wpos = N - 1 - int'(idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      tr_raddr_q <= '0;
      tr_rdata_q <= '0;
      tr_waddr_q <= '0;
      tr_wdata_q <= '0;
      tr_tcyc_q  <= '0;
    end else begin
      if (state_q == S_IDLE && accept) tr_tcyc_q <= '0;
      else if (busy)                   tr_tcyc_q <= tr_tcyc_q + 8'd1;
      if (state_q == S_RD && xfer_ack) begin
        tr_raddr_q[rpos*ADDR_W +: ADDR_W] <= xfer_addr;
        tr_rdata_q[rpos*8 +: 8]           <= mem_rdata;
      end
      if (state_q == S_WR && xfer_ack) begin
        tr_waddr_q[wpos*ADDR_W +: ADDR_W] <= xfer_addr;
        tr_wdata_q[wpos*8 +: 8]           <= xfer_wdata;
      end
    end
  end

  assign trace_valid   = done;
  assign trace_raddr   = tr_raddr_q;
  assign trace_rdata   = tr_rdata_q;
  assign trace_waddr   = tr_waddr_q;
  assign trace_wdata   = tr_wdata_q;
  assign trace_tcycles = tr_tcyc_q;
`endif

endmodule

// File: tb/tb_z80_ex_sp_seq.sv
// tb_z80_ex_sp_seq: bench for z80_ex_sp_seq. Instance 0 uses the default
// parameters (N=2, RD_PAD=1, WR_PAD=2); instance 1 uses N=4 with no pads.
// A memory responder acks after a configurable wait, a monitor logs every
// completed bus transfer, and a reference model derives the expected bus
// order, reg_out and done latency from SP, the register value and memory.
module tb_z80_ex_sp_seq;
  import z80_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT connections ----------------
  logic        start_a [2];
  logic [1:0]  sel_a   [2];
  logic [15:0] sp_a    [2];
  logic [31:0] rin_a   [2];
  logic        ack_a   [2] = '{1'b0, 1'b0};
  logic [7:0]  rdata_a [2] = '{8'h00, 8'h00};

  logic        req0, wr0, busy0, done0, req1, wr1, busy1, done1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic [15:0] rout0;
  logic [31:0] rout1;
  logic [1:0]  selout0, selout1;
  seq_state_t  st0, st1;

  logic        req_a [2], wr_a [2], busy_a [2], done_a [2];
  logic [15:0] addr_a [2];
  logic [7:0]  wdata_a [2];
  logic [31:0] rout_a [2];
  logic [1:0]  selout_a [2];
  seq_state_t  st_a [2];

  always_comb begin
    req_a[0] = req0;   req_a[1] = req1;
    wr_a[0]  = wr0;    wr_a[1]  = wr1;
    busy_a[0] = busy0; busy_a[1] = busy1;
    done_a[0] = done0; done_a[1] = done1;
    addr_a[0] = addr0; addr_a[1] = addr1;
    wdata_a[0] = wdata0; wdata_a[1] = wdata1;
    rout_a[0] = {16'h0000, rout0}; rout_a[1] = rout1;
    selout_a[0] = selout0; selout_a[1] = selout1;
    st_a[0] = st0; st_a[1] = st1;
  end

`ifdef Z80_EX_SP_TRACE_EN
  logic        tv0, tv1;
  logic [31:0] tra0, trd0_w, twa0, twd0_w;
  logic [63:0] tra1, twa1;
  logic [31:0] trd1, twd1;
  logic [7:0]  ttc0, ttc1;
  logic [15:0] trd0, twd0;
  assign trd0_w = {16'h0, trd0};
  assign twd0_w = {16'h0, twd0};
`endif

  z80_ex_sp_seq dut0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .reg_sel(sel_a[0]),
    .sp_in(sp_a[0]), .reg_in(rin_a[0][15:0]),
    .mem_req(req0), .mem_wr(wr0), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_ack(ack_a[0]), .mem_rdata(rdata_a[0]),
    .busy(busy0), .done(done0), .reg_out(rout0), .reg_sel_out(selout0),
    .state_dbg(st0)
`ifdef Z80_EX_SP_TRACE_EN
    , .trace_valid(tv0), .trace_raddr(tra0), .trace_rdata(trd0),
    .trace_waddr(twa0), .trace_wdata(twd0), .trace_tcycles(ttc0)
`endif
  );

  z80_ex_sp_seq #(.ADDR_W(16), .REG_BYTES(4), .RD_PAD(0), .WR_PAD(0)) dut1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .reg_sel(sel_a[1]),
    .sp_in(sp_a[1]), .reg_in(rin_a[1]),
    .mem_req(req1), .mem_wr(wr1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_ack(ack_a[1]), .mem_rdata(rdata_a[1]),
    .busy(busy1), .done(done1), .reg_out(rout1), .reg_sel_out(selout1),
    .state_dbg(st1)
`ifdef Z80_EX_SP_TRACE_EN
    , .trace_valid(tv1), .trace_raddr(tra1), .trace_rdata(trd1),
    .trace_waddr(twa1), .trace_wdata(twd1), .trace_tcycles(ttc1)
`endif
  );

  // ---------------- memory responder ----------------
  logic [7:0] mem [2][65536];
  int         ack_delay = 0;
  bit         spur_en   = 1'b0;
  int         wcnt [2]  = '{0, 0};

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (ack_a[p]) begin
        ack_a[p] = 1'b0;
        wcnt[p]  = 0;
      end
      if (req_a[p]) begin
        if (wcnt[p] >= ack_delay) begin
          ack_a[p]   = 1'b1;
          rdata_a[p] = wr_a[p] ? 8'($urandom) : mem[p][addr_a[p]];
        end else begin
          wcnt[p]++;
        end
      end else begin
        wcnt[p] = 0;
        // Stray acks while idle/padding must be ignored by the DUT.
        if (spur_en && $urandom_range(0, 3) == 0) begin
          ack_a[p]   = 1'b1;
          rdata_a[p] = 8'($urandom);
        end
      end
    end
  end

  // ---------------- scoreboard helpers / monitor ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [24:0] obs_q0 [$];
  logic [24:0] obs_q1 [$];
  int          done_cnt [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  bit          held_v [2]   = '{1'b0, 1'b0};
  logic [24:0] held [2];

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (done_a[p]) begin
        done_cnt[p]++;
        done_cyc[p] = cyc;
      end
      if (req_a[p]) begin
        if (held_v[p])
          chk($sformatf("bus_stable_p%0d", p), {7'h0, wr_a[p], addr_a[p], wdata_a[p]}, {7'h0, held[p]});
        if (ack_a[p]) begin
          if (p == 0) obs_q0.push_back({wr_a[p], addr_a[p], wr_a[p] ? wdata_a[p] : rdata_a[p]});
          else        obs_q1.push_back({wr_a[p], addr_a[p], wr_a[p] ? wdata_a[p] : rdata_a[p]});
          held_v[p] = 1'b0;
        end else begin
          held_v[p] = 1'b1;
          held[p]   = {wr_a[p], addr_a[p], wdata_a[p]};
        end
      end else begin
        held_v[p] = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full exchange with reference-model checking.
  task automatic run_op(input int p, input logic [1:0] sel, input logic [15:0] sp,
                        input logic [31:0] rv, input bit restart, input string tag);
    logic [24:0] exp_q [$];
    logic [24:0] oq [$];
    logic [31:0] exp_out;
    logic [15:0] a;
    int nb, pads, start_cyc, d0;
    bit kicked;
    nb = (p == 0) ? 2 : 4;
    pads = (p == 0) ? 3 : 0;
    exp_out = '0;
    for (int i = 0; i < nb; i++) begin
      a = sp + 16'(i);
      exp_q.push_back({1'b0, a, mem[p][a]});
      exp_out[i*8 +: 8] = mem[p][a];
    end
    for (int i = nb - 1; i >= 0; i--) begin
      a = sp + 16'(i);
      exp_q.push_back({1'b1, a, rv[i*8 +: 8]});
    end
    if (p == 0) obs_q0.delete(); else obs_q1.delete();
    d0 = done_cnt[p];
    start_a[p] = 1'b1; sel_a[p] = sel; sp_a[p] = sp; rin_a[p] = rv;
    start_cyc = cyc;
    tick(1);
    start_a[p] = 1'b0;
    sp_a[p] = 16'($urandom); rin_a[p] = $urandom; sel_a[p] = 2'($urandom_range(0, 2));
    @(negedge clk);
    chk({tag, "_busy"}, {31'h0, busy_a[p]}, 32'd1);
    kicked = 1'b0;
    for (int k = 0; k < 400 && done_cnt[p] == d0; k++) begin
      tick(1);
      if (restart && !kicked && st_a[p] == S_WR) begin
        kicked = 1'b1;
        start_a[p] = 1'b1;
      end else begin
        start_a[p] = 1'b0;
      end
    end
    start_a[p] = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt[p] - d0, 32'd1);
    chk({tag, "_latency"}, done_cyc[p] - start_cyc, 2*nb + pads + 1 + 2*nb*ack_delay);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'h0, done_a[p]}, 32'd0);
    chk({tag, "_idle_busy"}, {31'h0, busy_a[p]}, 32'd0);
    chk({tag, "_reg_out"}, rout_a[p], exp_out);
    chk({tag, "_reg_sel_out"}, {30'h0, selout_a[p]}, {30'h0, sel});
    if (p == 0) oq = obs_q0; else oq = obs_q1;
    chk({tag, "_xfer_count"}, oq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < oq.size())
        chk($sformatf("%s_xfer%0d", tag, i), {7'h0, oq[i]}, {7'h0, exp_q[i]});
    tick(1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] sp_r;
    logic [31:0] rv_r;
    int p_r, d0;
    for (int p = 0; p < 2; p++) begin
      start_a[p] = 1'b0; sel_a[p] = 2'd0; sp_a[p] = 16'h0; rin_a[p] = 32'h0;
    end
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'h0, st_a[0]}, {29'h0, S_IDLE});
    chk("rst_req", {31'h0, req_a[0]}, 32'd0);
    chk("rst_wr", {31'h0, wr_a[0]}, 32'd0);
    chk("rst_busy", {31'h0, busy_a[0]}, 32'd0);
    chk("rst_done", {31'h0, done_a[0]}, 32'd0);
    chk("rst_addr", {16'h0, addr_a[0]}, 32'd0);
    chk("rst_wdata", {24'h0, wdata_a[0]}, 32'd0);
    chk("rst_reg_out", rout_a[0], 32'd0);
    chk("rst_sel_out", {30'h0, selout_a[0]}, 32'd0);
    tick(1);

    // Reset during RPAD aborts without touching reg_out.
    mem[0][16'h1000] = 8'h34; mem[0][16'h1001] = 8'h12;
    d0 = done_cnt[0];
    start_a[0] = 1'b1; sel_a[0] = REG_SEL_HL; sp_a[0] = 16'h1000; rin_a[0] = 32'hABCD;
    tick(1);
    start_a[0] = 1'b0;
    for (int k = 0; k < 50 && st_a[0] != S_RPAD; k++) tick(1);
    chk("abort_reached_rpad", {29'h0, st_a[0]}, {29'h0, S_RPAD});
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {29'h0, st_a[0]}, {29'h0, S_IDLE});
    chk("abort_req", {31'h0, req_a[0]}, 32'd0);
    chk("abort_busy", {31'h0, busy_a[0]}, 32'd0);
    chk("abort_reg_out", rout_a[0], 32'd0);
    tick(15);
    chk("abort_no_done", done_cnt[0] - d0, 32'd0);

    // Reserved select: start is ignored.
    d0 = done_cnt[0];
    start_a[0] = 1'b1; sel_a[0] = REG_SEL_RSVD;
    tick(1);
    start_a[0] = 1'b0;
    @(negedge clk);
    chk("rsvd_busy", {31'h0, busy_a[0]}, 32'd0);
    tick(10);
    chk("rsvd_no_done", done_cnt[0] - d0, 32'd0);

    // HL, zero-wait.
    ack_delay = 0;
    run_op(0, REG_SEL_HL, 16'h1000, 32'h0000ABCD, 1'b0, "hl");
    // IY with address wrap.
    mem[0][16'hFFFF] = 8'h77; mem[0][16'h0000] = 8'h88;
    run_op(0, REG_SEL_IY, 16'hFFFF, 32'h00005566, 1'b0, "iy_wrap");
    // Three wait states per transfer.
    ack_delay = 3;
    run_op(0, REG_SEL_IX, 16'h1000, 32'h0000ABCD, 1'b0, "wait3");
    // Second start during WR is ignored.
    ack_delay = 1;
    run_op(0, REG_SEL_HL, 16'h1000, 32'h0000ABCD, 1'b1, "restart");
    // Four-byte instance, no pads.
    ack_delay = 0;
    mem[1][16'h0200] = 8'h11; mem[1][16'h0201] = 8'h22;
    mem[1][16'h0202] = 8'h33; mem[1][16'h0203] = 8'h44;
    run_op(1, REG_SEL_IX, 16'h0200, 32'hDEADBEEF, 1'b0, "n4");

    // Randomized exchanges with stray acks.
    spur_en = 1'b1;
    for (int it = 0; it < 10; it++) begin
      p_r  = $urandom_range(0, 1);
      sp_r = 16'($urandom);
      rv_r = $urandom;
      if (p_r == 0) rv_r[31:16] = 16'h0;
      for (int i = 0; i < 4; i++) mem[p_r][sp_r + 16'(i)] = 8'($urandom);
      ack_delay = $urandom_range(0, 3);
      run_op(p_r, 2'($urandom_range(0, 2)), sp_r, rv_r, 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_ex_sp_seq.md
Name: z80_ex_sp_seq

Overview:
- Sequencer that executes the memory phase of EX (SP),rr for HL, IX or IY after the decoder has finished M1 and any prefix fetch.
- Generalised to REG_BYTES-wide register pairs and ADDR_W-bit addresses.
- Issues N reads, then N writes in reverse order, with the internal pad T-states the Z80 inserts.
- Sits between the instruction decoder and the memory bus controller. Presents the exchanged register value back to the register file.

Parameters:
ADDR_W, 16, address width; all address arithmetic is modulo 2^ADDR_W
REG_BYTES, 2, bytes exchanged (N); legal range 1..8
RD_PAD, 1, internal T-states inserted after the last read
WR_PAD, 2, internal T-states inserted after the last write

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin; sampled only in IDLE
reg_sel  in  2  0=HL, 1=IX, 2=IY, 3=reserved (start ignored); latched at start
sp_in  in  ADDR_W  stack pointer, latched at start
reg_in  in  8*REG_BYTES  current register value, latched at start; byte 0 = low
mem_req  out  1  bus request, held until ack
mem_wr  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  ADDR_W  transfer address
mem_wdata  out  8  write byte
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it
mem_rdata  in  8  read byte
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse in DONE
reg_out  out  8*REG_BYTES  exchanged value, stable from done until the next start
reg_sel_out  out  2  latched reg_sel, for the register-file write enable

Behaviour:
- Reset: state=IDLE. mem_req, mem_wr, busy and done are 0. mem_addr=0, mem_wdata=0, reg_out=0, reg_sel_out=0.
- A reset asserted in any state aborts the operation: mem_req drops the next cycle and no partial reg_out update is applied.
- States: IDLE -> RD -> RPAD -> WR -> WPAD -> DONE -> IDLE.
- IDLE: on start with reg_sel!=3, latch sp, reg, sel; set idx=0; go to RD.
- RD: mem_req=1, mem_wr=0, mem_addr=sp+idx.
  - On ack, capture rdata into reg_out byte idx.
  - If idx==N-1, go to RPAD with pad counter=RD_PAD; else idx+1.
- RPAD: mem_req=0. Count down; at 0 go to WR with idx=N-1. RD_PAD=0 skips this state.
- WR: mem_req=1, mem_wr=1, mem_addr=sp+idx, mem_wdata=latched reg byte idx.
  - On ack: if idx==0, go to WPAD with counter=WR_PAD; else idx-1.
- WPAD: same counting as RPAD; at 0 go to DONE. WR_PAD=0 skips this state.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Address wrap: sp=FFFF, N=2 gives read FFFF then 0000, write 0000 then FFFF.
- Ack ordering: mem_addr, mem_wr and mem_wdata are stable while mem_req is high. A new request may assert the cycle after an ack.
- An ack arriving with mem_req low is ignored.
- start while busy is ignored and does not re-latch inputs.
- Minimum latency with zero-wait acks: 2N + RD_PAD + WR_PAD + 1 cycles from start to done.
- reg_out bytes are committed to the visible output only at DONE. A shadow register collects read data during RD.

Optional Feature:
- Macro: Z80_EX_SP_TRACE_EN.
- When defined, adds these outputs:
  - trace_valid: pulses with done.
  - trace_raddr[N], trace_rdata[N], trace_waddr[N], trace_wdata[N]: flat vectors in bus order.
  - trace_tcycles: 8 bits, count of busy cycles.
- These let the z80fi spec checkers compare bus order.
- When undefined, these ports and their registers are absent, and core timing is identical.

Decomposition:
- Shared package z80_seq_pkg holds:
  - state enum seq_state_t
  - reg_sel codes REG_SEL_HL/IX/IY
  - PAD counter width function clog2(max(RD_PAD,WR_PAD)+1)
- One natural sub-module: z80_bus_xfer, the single-transfer req/ack holder. The sequencer instantiates it once and drives addr/wr/wdata into it.

Test Plan:
- HL, sp=1000, reg_in=ABCD, mem[1000]=34, mem[1001]=12, zero-wait acks:
  - reads 1000 then 1001
  - writes 1001<-AB then 1000<-CD
  - reg_out=1234, done at cycle 8.
- IY, sp=FFFF, reg_in=5566, mem[FFFF]=77, mem[0000]=88:
  - addresses wrap to 0000
  - reg_out=8877, reg_sel_out=2.
- Ack delayed 3 cycles per transfer: mem_addr, mem_wr and mem_wdata held constant throughout; done at 8+12=20.
- start pulsed again during WR with different sp/reg_in: ignored; the original transfer sequence and reg_out are unchanged.
- reset asserted during RPAD: next cycle IDLE, mem_req=0, busy=0, reg_out keeps its pre-start value (0 after reset).
- REG_BYTES=4, RD_PAD=0, WR_PAD=0, sp=0200, reg_in=DEADBEEF:
  - reads 0200..0203
  - writes 0203<-DE, 0202<-AD, 0201<-BE, 0200<-EF
  - done at cycle 9.
